// File: rtl/microsequencer_if.sv
// microsequencer_if
//
// Bundles every non-clock, non-reset signal of the microsequencer.
//
// Signal summary (directions from the sequencer's point of view):
//   halt           in   freeze uPC, uIR, return stack and valid flag
//   dispatch_addr  in   decoder-supplied entry address for mode 3
//   cond_in        in   datapath status: 0 = MOC, 1 = Z, 2 = N, 3 = C
//   cs_we          in   control store write strobe
//   cs_waddr       in   control store write address
//   cs_wdata       in   control store write data
//   ctrl           out  control payload of the word held in uIR
//   upc            out  address of the word held in uIR
//   stack_err      out  sticky return stack overflow/underflow flag
//
// Handshake semantics: this bus has no valid/ready pair. The sequencer
// accepts every input on every rising clock edge. A high cs_we on an edge
// is one complete write; no back-pressure is possible. The outputs change
// only on a rising edge or on reset, and they are meaningful every cycle.
//
// modport slave  : the microsequencer itself
// modport master : whatever drives it (decoder, datapath, loader, bench)

interface microsequencer_if #(
  parameter int CW = 64,
  parameter int AW = 8
);

  logic              halt;
  logic [AW-1:0]     dispatch_addr;
  logic [3:0]        cond_in;
  logic              cs_we;
  logic [AW-1:0]     cs_waddr;
  logic [CW-1:0]     cs_wdata;
  logic [CW-AW-7:0]  ctrl;
  logic [AW-1:0]     upc;
  logic              stack_err;

  modport slave (
    input  halt,
    input  dispatch_addr,
    input  cond_in,
    input  cs_we,
    input  cs_waddr,
    input  cs_wdata,
    output ctrl,
    output upc,
    output stack_err
  );

  modport master (
    output halt,
    output dispatch_addr,
    output cond_in,
    output cs_we,
    output cs_waddr,
    output cs_wdata,
    input  ctrl,
    input  upc,
    input  stack_err
  );

endinterface

// File: rtl/microsequencer.sv
// microsequencer
//
// Microprogrammed control unit. It holds a writable control store, a
// registered microinstruction register (uIR), a microprogram counter
// (uPC), next-address logic with condition testing, and a LIFO return
// stack for microsubroutines.
//
// Control word layout (CW bits):
//   [AW-1:0]     CR   branch / call target
//   [AW+1:AW]    CS   selects which cond_in bit is tested
//   [AW+2]       INV  inverts the tested condition
//   [AW+5:AW+3]  N    next-address mode
//   [CW-1:AW+6]  payload, driven on ctrl
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    microsequencer_if.slave (halt, dispatch, conditions, control
//          store write port, ctrl / upc / stack_err outputs)

module microsequencer #(
  parameter int CW         = 64,
  parameter int AW         = 8,
  parameter int SD         = 4,
  parameter int RESET_ADDR = 0
) (
  input logic               clk,
  input logic               rst_n,
  microsequencer_if.slave   bus
);

  // Next-address modes held in the N field.
  localparam logic [2:0] N_SEQ  = 3'd0;  // uPC+1
  localparam logic [2:0] N_JMP  = 3'd1;  // CR
  localparam logic [2:0] N_BR   = 3'd2;  // T ? CR : uPC+1
  localparam logic [2:0] N_DISP = 3'd3;  // dispatch_addr
  localparam logic [2:0] N_CALL = 3'd4;  // CR, push uPC+1
  localparam logic [2:0] N_RET  = 3'd5;  // pop
  localparam logic [2:0] N_WAIT = 3'd6;  // T ? uPC+1 : uPC
  localparam logic [2:0] N_RST  = 3'd7;  // RESET_ADDR

  localparam logic [AW-1:0] RST_A = AW'(RESET_ADDR);

  // Stack pointer counts 0..SD, so it needs one more state than SD.
  localparam int SPW = $clog2(SD + 1);
  // Entry index width; storage is rounded up to a power of two so the
  // index always fully covers the array.
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;
  localparam int SDA = 2 ** IW;

  localparam logic [SPW-1:0] SP_FULL = SPW'(SD);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  // ------------------------------------------------------------------
  // Control store: write port is synchronous; the read feeding uIR is
  // combinational, so a same-edge write to the fetched address leaves
  // uIR with the old word.
  // ------------------------------------------------------------------
  logic [CW-1:0] cs_mem [2**AW];

  always_ff @(posedge clk) begin
    if (bus.cs_we) begin
      cs_mem[bus.cs_waddr] <= bus.cs_wdata;
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  logic [CW-1:0]  uir_q, uir_d;
  logic [AW-1:0]  upc_q, upc_d;
  logic           valid_q, valid_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           stack_err_q, stack_err_d;
  logic [AW-1:0]  stack_q [SDA];
  logic [AW-1:0]  stack_d [SDA];

  // ------------------------------------------------------------------
  // Field decode of the word currently in uIR
  // ------------------------------------------------------------------
  logic [AW-1:0] cr;
  logic [1:0]    cs_sel;
  logic          inv;
  logic [2:0]    mode;
  logic          t_cond;

  assign cr     = uir_q[AW-1:0];
  assign cs_sel = uir_q[AW+1:AW];
  assign inv    = uir_q[AW+2];
  assign mode   = uir_q[AW+5:AW+3];
  assign t_cond = bus.cond_in[cs_sel] ^ inv;

  // ------------------------------------------------------------------
  // Next-address logic
  // ------------------------------------------------------------------
  logic [AW-1:0] upc_inc;
  logic [AW-1:0] next_addr;
  logic          push_req;
  logic          pop_req;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic          stack_empty;
  logic          stack_full;

  assign upc_inc     = upc_q + AW'(1);  // wraps modulo 2^AW
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  assign push_idx    = IW'(sp_q);
  assign top_idx     = IW'(sp_q - SP_ONE);

  always_comb begin
    next_addr = upc_inc;
    push_req  = 1'b0;
    pop_req   = 1'b0;

    case (mode)
      N_SEQ:  next_addr = upc_inc;
      N_JMP:  next_addr = cr;
      N_BR:   next_addr = t_cond ? cr : upc_inc;
      N_DISP: next_addr = bus.dispatch_addr;
      N_CALL: begin
        // The jump is taken even when the push has to be dropped.
        next_addr = cr;
        push_req  = 1'b1;
      end
      N_RET: begin
        pop_req   = 1'b1;
        next_addr = stack_empty ? RST_A : stack_q[top_idx];
      end
      N_WAIT: next_addr = t_cond ? upc_inc : upc_q;
      N_RST:  next_addr = RST_A;
      default: next_addr = RST_A;
    endcase

    // uIR holds the reset value (all zeros) until the first fetch, so its
    // decoded fields mean nothing yet.
    if (!valid_q) begin
      next_addr = RST_A;
      push_req  = 1'b0;
      pop_req   = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // State update
  // ------------------------------------------------------------------
  always_comb begin
    uir_d       = uir_q;
    upc_d       = upc_q;
    valid_d     = valid_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    for (int i = 0; i < SDA; i++) begin
      stack_d[i] = stack_q[i];
    end

    if (!bus.halt) begin
      uir_d   = cs_mem[next_addr];
      upc_d   = next_addr;
      valid_d = 1'b1;

      if (push_req) begin
        if (stack_full) begin
          stack_err_d = 1'b1;
        end else begin
          stack_d[push_idx] = upc_inc;
          sp_d              = sp_q + SP_ONE;
        end
      end

      if (pop_req) begin
        if (stack_empty) begin
          stack_err_d = 1'b1;
        end else begin
          sp_d = sp_q - SP_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uir_q       <= '0;
      upc_q       <= RST_A;
      valid_q     <= 1'b0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < SDA; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      uir_q       <= uir_d;
      upc_q       <= upc_d;
      valid_q     <= valid_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      for (int i = 0; i < SDA; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.ctrl      = uir_q[CW-1:AW+6];
  assign bus.upc       = upc_q;
  assign bus.stack_err = stack_err_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer
//
// Directed bench for microsequencer (CW=64, AW=8, SD=4, RESET_ADDR=0).
// The driver pushes the expected {stack_err, upc, ctrl} right after each
// rising edge; a separate monitor pops and compares on the falling edge.

module tb_microsequencer;

  localparam int CW = 64;
  localparam int AW = 8;
  localparam int SD = 4;
  localparam int PW = CW - AW - 6;
  localparam int W  = 1 + AW + PW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  microsequencer_if #(.CW(CW), .AW(AW)) bus ();

  microsequencer #(
    .CW(CW), .AW(AW), .SD(SD), .RESET_ADDR(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  string        name_q [$];
  int           total = 0;
  int           bad   = 0;

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;
  string        mon_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = {bus.stack_err, bus.upc, bus.ctrl};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL %s: got err=%0b upc=%h ctrl=%h, want err=%0b upc=%h ctrl=%h",
                 mon_name, mon_got[W-1], mon_got[W-2 -: AW], mon_got[PW-1:0],
                 mon_exp[W-1], mon_exp[W-2 -: AW], mon_exp[PW-1:0]);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] pay(input logic [AW-1:0] a);
    return {26'h2A5A5A5, 16'hC0DE, a};
  endfunction

  function automatic logic [CW-1:0] mkw(input logic [PW-1:0] p, input logic [2:0] n,
                                        input logic inv, input logic [1:0] cs,
                                        input logic [AW-1:0] cr);
    return {p, n, inv, cs, cr};
  endfunction

  localparam logic [PW-1:0] NEWP = 50'h1_2345_6789_ABCD;

  task automatic cs_write(input logic [AW-1:0] a, input logic [CW-1:0] w);
    bus.cs_we    = 1'b1;
    bus.cs_waddr = a;
    bus.cs_wdata = w;
    @(posedge clk);
    #1;
    bus.cs_we    = 1'b0;
  endtask

  // One clock edge; the expectation describes the state after that edge.
  task automatic step(input string nm, input logic [AW-1:0] u,
                      input logic [PW-1:0] c, input logic e);
    @(posedge clk);
    exp_q.push_back({e, u, c});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // Reset, fetch words 0 and 1 (word 1 dispatches), land on address a.
  task automatic run_from(input logic [AW-1:0] a);
    rst_n             = 1'b0;
    bus.halt          = 1'b0;
    bus.cond_in       = 4'b0000;
    bus.dispatch_addr = a;
    step("reset", 8'h00, '0, 1'b0);
    rst_n = 1'b1;
    step("fetch0", 8'h00, pay(8'h00), 1'b0);
    step("fetch1", 8'h01, pay(8'h01), 1'b0);
    step("dispatch", a, pay(a), 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.halt          = 1'b0;
    bus.dispatch_addr = '0;
    bus.cond_in       = 4'b0000;
    bus.cs_we         = 1'b0;
    bus.cs_waddr      = '0;
    bus.cs_wdata      = '0;
    @(negedge clk);
    #1;

    // Load the control store while in reset.
    for (int a = 0; a < 256; a++) begin
      cs_write(AW'(a), mkw(pay(AW'(a)), 3'd0, 1'b0, 2'd0, 8'h00));
    end
    cs_write(8'h01, mkw(pay(8'h01), 3'd3, 1'b0, 2'd0, 8'h00));
    cs_write(8'h05, mkw(pay(8'h05), 3'd2, 1'b0, 2'd1, 8'h40));
    cs_write(8'h10, mkw(pay(8'h10), 3'd6, 1'b0, 2'd0, 8'h00));
    cs_write(8'h23, mkw(pay(8'h23), 3'd1, 1'b0, 2'd0, 8'h22));
    cs_write(8'h30, mkw(pay(8'h30), 3'd5, 1'b0, 2'd0, 8'h00));
    cs_write(8'h31, mkw(pay(8'h31), 3'd7, 1'b0, 2'd0, 8'h00));
    cs_write(8'h80, mkw(pay(8'h80), 3'd4, 1'b0, 2'd0, 8'h90));
    cs_write(8'h90, mkw(pay(8'h90), 3'd4, 1'b0, 2'd0, 8'hA0));
    cs_write(8'hA0, mkw(pay(8'hA0), 3'd4, 1'b0, 2'd0, 8'hB0));
    cs_write(8'hB0, mkw(pay(8'hB0), 3'd4, 1'b0, 2'd0, 8'hC0));
    cs_write(8'hC0, mkw(pay(8'hC0), 3'd5, 1'b0, 2'd0, 8'h00));
    cs_write(8'hB1, mkw(pay(8'hB1), 3'd5, 1'b0, 2'd0, 8'h00));
    cs_write(8'hA1, mkw(pay(8'hA1), 3'd5, 1'b0, 2'd0, 8'h00));
    cs_write(8'h91, mkw(pay(8'h91), 3'd5, 1'b0, 2'd0, 8'h00));
    cs_write(8'h82, mkw(pay(8'h82), 3'd4, 1'b0, 2'd0, 8'hD0));
    cs_write(8'hD0, mkw(pay(8'hD0), 3'd4, 1'b0, 2'd0, 8'hD8));
    cs_write(8'hD8, mkw(pay(8'hD8), 3'd4, 1'b0, 2'd0, 8'hE0));
    cs_write(8'hE0, mkw(pay(8'hE0), 3'd4, 1'b0, 2'd0, 8'hE8));
    cs_write(8'hE8, mkw(pay(8'hE8), 3'd4, 1'b0, 2'd0, 8'hF0));
    cs_write(8'hF0, mkw(pay(8'hF0), 3'd5, 1'b0, 2'd0, 8'h00));

    // Conditional branch on Z.
    run_from(8'h05);
    bus.cond_in = 4'b0010;
    step("br_z1_taken", 8'h40, pay(8'h40), 1'b0);
    step("br_after_taken", 8'h41, pay(8'h41), 1'b0);
    run_from(8'h05);
    bus.cond_in = 4'b0000;
    step("br_z0_fall", 8'h06, pay(8'h06), 1'b0);
    rst_n = 1'b0;
    cs_write(8'h05, mkw(pay(8'h05), 3'd2, 1'b1, 2'd1, 8'h40));
    run_from(8'h05);
    bus.cond_in = 4'b0010;
    step("br_inv_z1_fall", 8'h06, pay(8'h06), 1'b0);
    run_from(8'h05);
    bus.cond_in = 4'b0000;
    step("br_inv_z0_taken", 8'h40, pay(8'h40), 1'b0);

    // MOC wait.
    run_from(8'h10);
    bus.cond_in = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      step("moc_wait", 8'h10, pay(8'h10), 1'b0);
    end
    bus.cond_in = 4'b0001;
    step("moc_go", 8'h11, pay(8'h11), 1'b0);

    // Nested calls and returns, with halt on a call and on a return word.
    run_from(8'h80);
    bus.halt = 1'b1;
    step("halt_call_0", 8'h80, pay(8'h80), 1'b0);
    step("halt_call_1", 8'h80, pay(8'h80), 1'b0);
    bus.halt = 1'b0;
    step("call1", 8'h90, pay(8'h90), 1'b0);
    step("call2", 8'hA0, pay(8'hA0), 1'b0);
    step("call3", 8'hB0, pay(8'hB0), 1'b0);
    step("call4", 8'hC0, pay(8'hC0), 1'b0);
    bus.halt = 1'b1;
    step("halt_ret_0", 8'hC0, pay(8'hC0), 1'b0);
    step("halt_ret_1", 8'hC0, pay(8'hC0), 1'b0);
    bus.halt = 1'b0;
    step("ret4", 8'hB1, pay(8'hB1), 1'b0);
    step("ret3", 8'hA1, pay(8'hA1), 1'b0);
    step("ret2", 8'h91, pay(8'h91), 1'b0);
    step("ret1", 8'h81, pay(8'h81), 1'b0);
    step("seq_82", 8'h82, pay(8'h82), 1'b0);
    step("ncall1", 8'hD0, pay(8'hD0), 1'b0);
    step("ncall2", 8'hD8, pay(8'hD8), 1'b0);
    step("ncall3", 8'hE0, pay(8'hE0), 1'b0);
    step("ncall4", 8'hE8, pay(8'hE8), 1'b0);
    step("ncall5_ovf", 8'hF0, pay(8'hF0), 1'b1);
    step("ret_after_ovf", 8'hE1, pay(8'hE1), 1'b1);

    // Dispatch, halt on a plain word, wrap, mode 7.
    run_from(8'hA7);
    step("seq_a8", 8'hA8, pay(8'hA8), 1'b0);
    bus.halt = 1'b1;
    step("halt_seq_0", 8'hA8, pay(8'hA8), 1'b0);
    step("halt_seq_1", 8'hA8, pay(8'hA8), 1'b0);
    bus.halt = 1'b0;
    step("after_halt", 8'hA9, pay(8'hA9), 1'b0);
    run_from(8'hFF);
    step("wrap", 8'h00, pay(8'h00), 1'b0);
    step("wrap_next", 8'h01, pay(8'h01), 1'b0);
    run_from(8'h31);
    step("mode7", 8'h00, pay(8'h00), 1'b0);

    // Read-during-write on the fetched address.
    run_from(8'h21);
    bus.cs_we    = 1'b1;
    bus.cs_waddr = 8'h22;
    bus.cs_wdata = mkw(NEWP, 3'd0, 1'b0, 2'd0, 8'h00);
    step("rdw_old", 8'h22, pay(8'h22), 1'b0);
    bus.cs_we    = 1'b0;
    step("rdw_jump", 8'h23, pay(8'h23), 1'b0);
    step("rdw_new", 8'h22, NEWP, 1'b0);
    step("rdw_new_seq", 8'h23, pay(8'h23), 1'b0);

    // Asynchronous reset in the middle of a call.
    run_from(8'h80);
    step("mid_call", 8'h90, pay(8'h90), 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.push_back({1'b0, 8'h00, {PW{1'b0}}});
    name_q.push_back("async_reset");
    @(negedge clk);
    #1;
    // After reset the stack must be empty: a return underflows.
    run_from(8'h30);
    step("pop_empty", 8'h00, pay(8'h00), 1'b1);
    step("pop_empty_next", 8'h01, pay(8'h01), 1'b1);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised microprogrammed control unit for the ARM datapath. It replaces the fixed 256 x 64 combinational control ROM with a writable control store, a registered microinstruction register (uIR), a microprogram counter (uPC), next-address logic with condition testing, and a return stack for microsubroutines. It sits between the instruction decoder, which supplies dispatch addresses, and the datapath, which receives the control payload and returns status conditions.

## Interface
- CW, default 64: control word width.
- AW, default 8: control store address width (depth 2^AW).
- SD, default 4: return stack depth (1..16).
- RESET_ADDR, default 0: microaddress fetched after reset and on mode 7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- halt  in  1  freezes uPC, uIR, stack and valid while high.
- dispatch_addr  in  AW  decoder-supplied entry address (mode 3).
- cond_in  in  4  datapath status (bit 0 = MOC, 1 = Z, 2 = N, 3 = C).
- cs_we  in  1  control store write enable.
- cs_waddr  in  AW  write address.
- cs_wdata  in  CW  write data.
- ctrl  out  CW-AW-6  control payload, cw[CW-1:AW+6] of uIR.
- upc  out  AW  address of the microinstruction currently in uIR.
- stack_err  out  1  sticky overflow/underflow flag.

## Operation
- Control word fields: CR = cw[AW-1:0] (branch target); CS = cw[AW+1:AW] (selects cond_in[CS]); INV = cw[AW+2]; N = cw[AW+5:AW+3] (next-address mode); the remaining bits form the payload.
- Test condition: T = cond_in[CS] XOR INV.
- Next address, combinational from uIR and uPC:
  - N=0: uPC+1.
  - N=1: CR.
  - N=2: T ? CR : uPC+1.
  - N=3: dispatch_addr.
  - N=4: CR, and push uPC+1.
  - N=5: pop the top of stack.
  - N=6: T ? uPC+1 : uPC (wait, e.g. on MOC).
  - N=7: RESET_ADDR.
- uPC+1 wraps modulo 2^AW; 2^AW-1 increments to 0.
- valid flag: while valid=0, the next address is RESET_ADDR regardless of uIR.
- Stack: LIFO, SD entries, with a pointer count 0..SD.
  - Push when full: the push is dropped, the jump to CR still occurs, and stack_err is set.
  - Pop when empty: the next address is RESET_ADDR and stack_err is set.
  - stack_err clears only on reset.
- Control store: an array of 2^AW words, written synchronously when cs_we=1. Contents are not reset.
- halt=1: no register changes. Control store writes still occur.

## Timing
- Each unhalted edge: uIR <= CS[next], uPC <= next, valid <= 1, and the stack updates.
- Reset (asynchronous assert): uPC=RESET_ADDR, uIR=0, so ctrl=0; valid=0, stack count=0, stack_err=0.
- First edge after rst_n deasserts: uIR <= CS[RESET_ADDR], upc=RESET_ADDR.
- Latency: a microinstruction drives ctrl for exactly one cycle per unhalted edge. The branch decision uses cond_in sampled in the cycle the branching word is in uIR, and the target appears on ctrl the next cycle.
- Read-during-write to the address being fetched: uIR receives the old contents. The new word is visible from the next fetch.
- Reset asserted mid-operation: immediate return to reset values; the stack is discarded.
- halt and a mode-4/5 word together: no push or pop occurs until halt drops.

## Test plan
- Reset/fetch: CS[0] has N=0 and payload P0; CS[1] has payload P1. Release rst_n -> ctrl=0 before the first edge, then ctrl=P0 with upc=0, then ctrl=P1 with upc=1.
- Conditional branch: word at 5 has N=2, CS=1, INV=0, CR=0x40. With Z=1 -> next upc=0x40. With Z=0 -> next upc=6. With INV=1 and Z=1 -> next upc=6.
- MOC wait: word at 0x10 has N=6, CS=0. Hold cond_in[0]=0 for 3 cycles -> upc stays 0x10 for 4 cycles. Raise MOC -> upc=0x11.
- Call/return nesting with SD=4: 4 nested calls then 4 returns -> each return lands on caller+1 and stack_err=0. A 5th nested call -> stack_err=1 and the jump still taken. Return with an empty stack -> upc=RESET_ADDR.
- Dispatch, wrap and halt: N=3 with dispatch_addr=0xA7 -> upc=0xA7. N=0 at 0xFF -> upc=0x00. halt held 2 cycles -> upc and ctrl unchanged.
- Write port: write 0x22 while uIR is fetching 0x22 -> old word loaded. Refetch 0x22 -> new word loaded. Async reset asserted mid-call -> upc=RESET_ADDR and stack empty.
